// File: rtl/gmii_chk_pkg.sv
// Shared types and constants for the GMII frame checker and its CRC helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gmii_chk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } chk_state_t;

  // Bit positions inside err_flags
  localparam int ERR_PRE   = 0;
  localparam int ERR_SFD   = 1;
  localparam int ERR_CRC   = 2;
  localparam int ERR_RUNT  = 3;
  localparam int ERR_GIANT = 4;
  localparam int ERR_IFG   = 5;
  localparam int ERR_W     = 6;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  // Number of 0x55 bytes that must precede the SFD
  localparam logic [2:0] PRE_CNT  = 3'd7;

endpackage

// File: rtl/crc32_d8.sv
// Next-state of the reflected Ethernet CRC-32 register after one byte, LSB first.
// Latency: purely combinational.
// Backpressure: none.
module crc32_d8
  import gmii_chk_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] w_crc;

  // Serial LFSR unrolled over the eight data bits, bit 0 first
  always_comb begin
    w_crc = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (w_crc[0] ^ data[i]) begin
        w_crc = (w_crc >> 1) ^ CRC_POLY;
      end else begin
        w_crc = w_crc >> 1;
      end
    end
  end

  assign crc_out = w_crc;

endmodule

// File: rtl/gmii_tx_frame_checker.sv
// Passive GMII TX monitor: preamble/SFD, FCS, length and inter-frame-gap checks per frame.
// Latency: status and counters update one cycle after gmii_tx_en is first sampled low.
// Backpressure: none; taps the stream, never stalls or alters it.
module gmii_tx_frame_checker
  import gmii_chk_pkg::*;
#(
  parameter int MIN_IFG = 12,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 32
) (
  input  logic             gmii_tx_clk,
  input  logic             rst_n,
  input  logic             gmii_tx_en,
  input  logic [7:0]       gmii_txd,
  input  logic             clear_cnt,
  output logic             frame_done,
  output logic             frame_good,
  output logic [15:0]      frame_len,
  output logic [5:0]       err_flags,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  chk_state_t       r_state;
  logic             r_armed;      // a low enable has been seen since reset
  logic [7:0]       r_idle_cnt;
  logic [2:0]       r_pre_cnt;    // 0x55 bytes accepted so far
  logic [31:0]      r_crc;
  logic [15:0]      r_len;
  logic [ERR_W-1:0] r_err;        // errors collected during the current frame
  logic             r_done;
  logic             r_good;
  logic [15:0]      r_frame_len;
  logic [ERR_W-1:0] r_err_flags;
  logic [CNT_W-1:0] r_good_cnt;
  logic [CNT_W-1:0] r_bad_cnt;

  logic [31:0]      w_crc_next;
  logic [2:0]       w_pre_seen;
  chk_state_t       w_pre_nxt;
  logic [ERR_W-1:0] w_byte_err;
  logic [ERR_W-1:0] w_start_err;
  logic [ERR_W-1:0] w_end_err;
  logic [15:0]      w_end_len;
  logic             w_frame_end;
  logic             w_end_good;
  logic             w_ifg_short;
  logic [CNT_W-1:0] w_good_base;
  logic [CNT_W-1:0] w_bad_base;

  crc32_d8 u_crc (
    .crc_in  (r_crc),
    .data    (gmii_txd),
    .crc_out (w_crc_next)
  );

  // The first byte of a frame arrives while still in IDLE, so it counts as byte 1
  assign w_pre_seen  = (r_state == PREAMBLE) ? r_pre_cnt : 3'd0;
  assign w_ifg_short = int'(r_idle_cnt) < MIN_IFG;
  assign w_frame_end = !gmii_tx_en && (r_state != IDLE);
  assign w_end_good  = (w_end_err == '0);

  // Classify one preamble-phase byte: more 0x55, SFD (possibly early), or broken framing
  always_comb begin
    w_byte_err = '0;
    w_pre_nxt  = DROP;
    if (gmii_txd == SFD_BYTE) begin
      w_pre_nxt            = DATA;
      w_byte_err[ERR_PRE]  = (w_pre_seen < PRE_CNT);
    end else if (gmii_txd == PRE_BYTE && w_pre_seen < PRE_CNT) begin
      w_pre_nxt            = PREAMBLE;
    end else begin
      w_byte_err[ERR_SFD]  = 1'b1;
    end
    w_start_err          = w_byte_err;
    w_start_err[ERR_IFG] = w_ifg_short;
  end

  // Final verdict for a frame ending this cycle; only frames that reached DATA get CRC/length checks
  always_comb begin
    w_end_err = r_err;
    w_end_len = '0;
    case (r_state)
      PREAMBLE: w_end_err[ERR_PRE] = 1'b1;
      DATA: begin
        w_end_len            = r_len;
        w_end_err[ERR_CRC]   = (r_crc != CRC_RESIDUE);
        w_end_err[ERR_RUNT]  = (int'(r_len) < MIN_LEN);
        w_end_err[ERR_GIANT] = (int'(r_len) > MAX_LEN);
      end
      default: ;
    endcase
  end

  // Frame-tracking FSM with registered status outputs
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_armed     <= 1'b0;
      r_idle_cnt  <= 8'hFF;
      r_pre_cnt   <= '0;
      r_crc       <= CRC_INIT;
      r_len       <= '0;
      r_err       <= '0;
      r_done      <= 1'b0;
      r_good      <= 1'b0;
      r_frame_len <= '0;
      r_err_flags <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_frame_end) begin
        r_state     <= IDLE;
        r_done      <= 1'b1;
        r_good      <= w_end_good;
        r_frame_len <= w_end_len;
        r_err_flags <= w_end_err;
        // This first low cycle is idle cycle 1 of the next gap
        r_idle_cnt  <= 8'd1;
      end else begin
        case (r_state)
          IDLE: begin
            if (!gmii_tx_en) begin
              r_armed <= 1'b1;
              if (r_idle_cnt != 8'hFF) begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
              end
            end else if (r_armed) begin
              // A frame already running at reset release is skipped until enable drops
              r_state   <= w_pre_nxt;
              r_pre_cnt <= w_pre_seen + 3'd1;
              r_crc     <= CRC_INIT;
              r_len     <= '0;
              r_err     <= w_start_err;
            end
          end
          PREAMBLE: begin
            r_state   <= w_pre_nxt;
            r_pre_cnt <= w_pre_seen + 3'd1;
            r_crc     <= CRC_INIT;
            r_len     <= '0;
            r_err     <= r_err | w_byte_err;
          end
          DATA: begin
            r_crc <= w_crc_next;
            if (r_len != 16'hFFFF) begin
              r_len <= r_len + 16'd1;
            end
          end
          DROP: ;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Clear takes effect before a same-cycle increment so the increment survives
  assign w_good_base = clear_cnt ? '0 : r_good_cnt;
  assign w_bad_base  = clear_cnt ? '0 : r_bad_cnt;

  // Saturating good/bad frame counters
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_good_cnt <= w_good_base;
      r_bad_cnt  <= w_bad_base;
      if (w_frame_end) begin
        if (w_end_good) begin
          if (w_good_base != '1) begin
            r_good_cnt <= w_good_base + CNT_ONE;
          end
        end else if (w_bad_base != '1) begin
          r_bad_cnt <= w_bad_base + CNT_ONE;
        end
      end
    end
  end

  assign frame_done = r_done;
  assign frame_good = r_good;
  assign frame_len  = r_frame_len;
  assign err_flags  = r_err_flags;
  assign good_cnt   = r_good_cnt;
  assign bad_cnt    = r_bad_cnt;

endmodule

// File: tb/tb_gmii_tx_frame_checker.sv
// Bench for gmii_tx_frame_checker: directed frames, frame-level reference model, per-cycle compare.
// Latency: expects status one cycle after the first low enable sample.
// Backpressure: none; stimulus is one byte per clock.
module tb_gmii_tx_frame_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [7:0]  txd = 8'h00;
  logic        clear_cnt = 1'b0;
  logic        frame_done;
  logic        frame_good;
  logic [15:0] frame_len;
  logic [5:0]  err_flags;
  logic [31:0] good_cnt;
  logic [31:0] bad_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gmii_tx_frame_checker #(
    .MIN_IFG (12),
    .MIN_LEN (64),
    .MAX_LEN (1518),
    .CNT_W   (32)
  ) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .gmii_tx_en  (tx_en),
    .gmii_txd    (txd),
    .clear_cnt   (clear_cnt),
    .frame_done  (frame_done),
    .frame_good  (frame_good),
    .frame_len   (frame_len),
    .err_flags   (err_flags),
    .good_cnt    (good_cnt),
    .bad_cnt     (bad_cnt)
  );

  typedef struct {
    int         due;
    logic [5:0] fl;
    int         len;
  } exp_t;

  exp_t           q[$];
  byte unsigned   frm[$];
  int             cyc = 0;
  logic           clr_last = 1'b0;
  int             idle_run = 255;
  bit             fresh = 1'b1;
  bit             pend_vld = 1'b0;
  bit             pend_clr = 1'b0;
  exp_t           pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Standard Ethernet FCS (with final inversion) over frm[st +: cnt]
  function automatic logic [31:0] fcs_of(input int st, input int cnt);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < cnt; k++) begin
      c ^= {24'd0, frm[st + k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame-level rules: leading 0x55 run, SFD position, FCS of body, length window, gap
  function automatic void model(input int gap, input bit frsh, output logic [5:0] fl, output int len);
    int i;
    int st;
    int n;
    logic [31:0] rx;
    fl  = '0;
    len = 0;
    if (!frsh && gap < 12) fl[5] = 1'b1;
    i = 0;
    while (i < frm.size() && i < 7 && frm[i] == 8'h55) i++;
    if (i == frm.size()) begin
      fl[0] = 1'b1;
    end else if (frm[i] != 8'hD5) begin
      fl[1] = 1'b1;
    end else begin
      if (i < 7) fl[0] = 1'b1;
      st  = i + 1;
      n   = frm.size() - st;
      len = (n > 65535) ? 65535 : n;
      if (n >= 4) rx = {frm[st+n-1], frm[st+n-2], frm[st+n-3], frm[st+n-4]};
      else        rx = '0;
      if (n < 4 || fcs_of(st, n - 4) != rx) fl[2] = 1'b1;
      if (len < 64)   fl[3] = 1'b1;
      if (len > 1518) fl[4] = 1'b1;
    end
  endfunction

  // tot < 0 builds a preamble-only burst
  task automatic build(input int n55, input logic [7:0] sfd, input int tot, input bit flip);
    logic [31:0] f;
    frm.delete();
    repeat (n55) frm.push_back(8'h55);
    if (tot >= 0) begin
      frm.push_back(sfd);
      for (int k = 0; k < tot - 4; k++) frm.push_back(8'((k * 13 + tot) & 255));
      f = fcs_of(n55 + 1, tot - 4);
      for (int k = 0; k < 4; k++) frm.push_back(f[8*k +: 8]);
      if (flip) frm[frm.size()-1] ^= 8'h01;
    end
  endtask

  task automatic drive_low();
    @(negedge clk);
    clear_cnt = 1'b0;
    if (tx_en && pend_vld) begin
      pend.due = cyc + 1;
      q.push_back(pend);
      pend_vld  = 1'b0;
      clear_cnt = pend_clr;
    end
    tx_en = 1'b0;
    txd   = 8'h00;
    if (idle_run < 255) idle_run++;
  endtask

  task automatic drive_high(input logic [7:0] b);
    @(negedge clk);
    tx_en     = 1'b1;
    txd       = b;
    clear_cnt = 1'b0;
    idle_run  = 0;
  endtask

  task automatic send(input int idle_before, input bit clr);
    repeat (idle_before) drive_low();
    model(idle_run, fresh, pend.fl, pend.len);
    fresh    = 1'b0;
    pend_vld = 1'b1;
    pend_clr = clr;
    foreach (frm[i]) drive_high(frm[i]);
  endtask

  task automatic flush(input int n);
    repeat (n) drive_low();
  endtask

  always @(posedge clk) begin
    cyc      = cyc + 1;
    clr_last = clear_cnt;
  end

  // Model-side outputs, checked against the DUT on every cycle
  logic [5:0]  m_fl = '0;
  logic [15:0] m_len = '0;
  logic        m_good = 1'b0;
  logic [31:0] m_gc = '0;
  logic [31:0] m_bc = '0;

  always @(negedge clk) begin
    logic e_done;
    e_done = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_fl = '0; m_len = '0; m_good = 1'b0; m_gc = '0; m_bc = '0;
    end else begin
      e_done = (q.size() > 0) && (q[0].due == cyc);
      if (clr_last) begin
        m_gc = '0;
        m_bc = '0;
      end
      if (e_done) begin
        m_fl   = q[0].fl;
        m_len  = 16'(q[0].len);
        m_good = (q[0].fl == '0);
        if (m_good) m_gc++;
        else        m_bc++;
        void'(q.pop_front());
      end
    end
    chk("done",     {31'd0, frame_done}, {31'd0, e_done});
    chk("good",     {31'd0, frame_good}, {31'd0, m_good});
    chk("len",      {16'd0, frame_len},  {16'd0, m_len});
    chk("flags",    {26'd0, err_flags},  {26'd0, m_fl});
    chk("good_cnt", good_cnt, m_gc);
    chk("bad_cnt",  bad_cnt,  m_bc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Pin the model CRC against the well-known check value of "123456789"
    frm.delete();
    for (int k = 0; k < 9; k++) frm.push_back(8'(8'h31 + k));
    chk("crc_ref", fcs_of(0, 9), 32'hCBF4_3926);

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Earliest frame the checker can see after reset; gap never flagged
    build(7, 8'hD5, 64, 1'b0);
    send(1, 1'b0);
    flush(3);
    chk("lit_t1_len", {16'd0, frame_len}, 32'd64);
    chk("lit_t1_flags", {26'd0, err_flags}, 32'h0);
    chk("lit_t1_good_cnt", good_cnt, 32'd1);

    // Corrupted FCS
    build(7, 8'hD5, 64, 1'b1);
    send(12, 1'b0);
    flush(3);
    chk("lit_t2_flags", {26'd0, err_flags}, 32'h04);
    chk("lit_t2_bad_cnt", bad_cnt, 32'd1);
    chk("lit_t2_good_cnt", good_cnt, 32'd1);

    // Early SFD: preamble error, CRC still checked
    build(5, 8'hD5, 64, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_t3_flags", {26'd0, err_flags}, 32'h01);

    // Bad SFD after full preamble
    build(7, 8'h5D, 64, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_t4_flags", {26'd0, err_flags}, 32'h02);
    chk("lit_t4_len", {16'd0, frame_len}, 32'd0);

    // Enable drops inside the preamble
    build(4, 8'hD5, -1, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_t5_flags", {26'd0, err_flags}, 32'h01);

    // Runt, giant and maximum legal length
    build(7, 8'hD5, 63, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_runt_flags", {26'd0, err_flags}, 32'h08);
    build(7, 8'hD5, 1519, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_giant_flags", {26'd0, err_flags}, 32'h10);
    chk("lit_giant_len", {16'd0, frame_len}, 32'd1519);
    build(7, 8'hD5, 1518, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_max_good", {31'd0, frame_good}, 32'd1);

    // Gap of 11, then exactly 12, then back-to-back
    build(7, 8'hD5, 64, 1'b0);
    send(12, 1'b0);
    send(11, 1'b0);
    flush(3);
    chk("lit_ifg11_flags", {26'd0, err_flags}, 32'h20);
    send(12, 1'b0);
    send(12, 1'b0);
    flush(3);
    chk("lit_ifg12_flags", {26'd0, err_flags}, 32'h0);
    send(12, 1'b0);
    send(1, 1'b0);
    flush(3);
    chk("lit_ifg1_flags", {26'd0, err_flags}, 32'h20);

    // Clear coinciding with a good frame end
    send(12, 1'b1);
    flush(3);
    chk("lit_clr_good_cnt", good_cnt, 32'd1);
    chk("lit_clr_bad_cnt", bad_cnt, 32'd0);

    // Reset in the middle of DATA; the tail of that frame must be ignored
    build(7, 8'hD5, 100, 1'b0);
    flush(12);
    for (int k = 0; k < 40; k++) drive_high(frm[k]);
    @(posedge clk);
    #2 rst_n = 1'b0;
    idle_run = 255;
    fresh    = 1'b1;
    pend_vld = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 40; k < frm.size(); k++) drive_high(frm[k]);
    build(7, 8'hD5, 64, 1'b0);
    send(12, 1'b0);
    flush(5);
    chk("lit_rst_good_cnt", good_cnt, 32'd1);
    chk("lit_rst_bad_cnt", bad_cnt, 32'd0);
    chk("lit_rst_flags", {26'd0, err_flags}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
